// File: rtl/locker_pkg.sv
// Shared definitions for the lock interface: default combination and sender FSM states.
package locker_pkg;

  localparam int unsigned CODE_LEN_DEF = 5;

  // Default combination; bit k is pressed at step k
  localparam logic [CODE_LEN_DEF-1:0] CODE_B0_DEF = 5'b10100;
  localparam logic [CODE_LEN_DEF-1:0] CODE_B1_DEF = 5'b01011;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_SEND = 3'd1,
    ST_GAP  = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } sender_state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lock_step_timer.sv
// Loadable down-counter with a registered zero flag; shared by the GAP and WAIT countdowns.
module lock_step_timer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             zero_q;

  // Load has priority; decrement saturates at zero so the count never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Count register and zero flag, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= (cnt_d == '0);
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/lock_code_sender.sv
// Auto-dialer: plays a stored two-button combination into a lock and reports whether it opened.
module lock_code_sender
  import locker_pkg::*;
#(
  parameter int unsigned            CODE_LEN   = CODE_LEN_DEF,
  parameter logic [CODE_LEN-1:0]    CODE_B0    = CODE_B0_DEF,
  parameter logic [CODE_LEN-1:0]    CODE_B1    = CODE_B1_DEF,
  parameter int unsigned            GAP_CYCLES = 0,
  parameter int unsigned            TIMEOUT    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                load_en,
  input  logic [CODE_LEN-1:0] code_b0_in,
  input  logic [CODE_LEN-1:0] code_b1_in,
  input  logic                unlock,
  output logic                button_0,
  output logic                button_1,
  output logic                busy,
  output logic                done,
  output logic                success
);

  localparam int unsigned STEP_W   = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam int unsigned CNT_W    = (max_u(GAP_CYCLES, TIMEOUT) > 0) ?
                                     $clog2(max_u(GAP_CYCLES, TIMEOUT) + 1) : 1;
  localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam int unsigned TMO_LOAD = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  sender_state_e       state_q, state_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic [CODE_LEN-1:0] code_b0_q, code_b0_d;
  logic [CODE_LEN-1:0] code_b1_q, code_b1_d;
  logic                success_q, success_d;
  logic                button_0_q, button_0_d;
  logic                button_1_q, button_1_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                tmr_load;
  logic [CNT_W-1:0]    tmr_val;
  logic                tmr_dec;
  logic                tmr_zero;

  lock_step_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_o     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, step/code/result bookkeeping and timer control
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    code_b0_d = code_b0_q;
    code_b1_d = code_b1_q;
    success_d = success_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (load_en) begin
          code_b0_d = code_b0_in;
          code_b1_d = code_b1_in;
        end
        if (start) begin
          state_d   = ST_SEND;
          step_d    = '0;
          success_d = 1'b0;
        end
      end
      ST_SEND: begin
        if (step_q < STEP_W'(CODE_LEN - 1)) begin
          step_d = step_q + STEP_W'(1);
          if (GAP_CYCLES > 0) begin
            state_d  = ST_GAP;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(GAP_LOAD);
          end
        end else begin
          state_d  = ST_WAIT;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(TMO_LOAD);
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          state_d = ST_SEND;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_WAIT: begin
        if (unlock) begin
          state_d   = ST_DONE;
          success_d = 1'b1;
        end else if (tmr_zero) begin
          state_d = ST_DONE;
        end else begin
          tmr_dec = 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output next-values derived from the next state so they align with the state register
  always_comb begin
    button_0_d = 1'b0;
    button_1_d = 1'b0;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    if (state_d == ST_SEND) begin
      button_0_d = code_b0_d[step_d];
      button_1_d = code_b1_d[step_d];
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      step_q     <= '0;
      code_b0_q  <= CODE_B0;
      code_b1_q  <= CODE_B1;
      success_q  <= 1'b0;
      button_0_q <= 1'b0;
      button_1_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      step_q     <= step_d;
      code_b0_q  <= code_b0_d;
      code_b1_q  <= code_b1_d;
      success_q  <= success_d;
      button_0_q <= button_0_d;
      button_1_q <= button_1_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign button_0 = button_0_q;
  assign button_1 = button_1_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign success  = success_q;

endmodule

// File: tb/tb_lock_code_sender.sv
// Directed bench for lock_code_sender: default and gapped instances plus a small lock model.
module tb_lock_code_sender;
  import locker_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, load_en, use_lock;
  logic [4:0] code_b0_in, code_b1_in;
  logic       unlock;
  logic       button_0, button_1, busy, done, success;

  logic       g_start;
  logic       g_button_0, g_button_1, g_busy, g_done, g_success;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lock_code_sender dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .load_en    (load_en),
    .code_b0_in (code_b0_in),
    .code_b1_in (code_b1_in),
    .unlock     (unlock),
    .button_0   (button_0),
    .button_1   (button_1),
    .busy       (busy),
    .done       (done),
    .success    (success)
  );

  lock_code_sender #(.GAP_CYCLES(2)) dut_gap (
    .clk        (clk),
    .rst        (rst),
    .start      (g_start),
    .load_en    (1'b0),
    .code_b0_in (5'b00000),
    .code_b1_in (5'b00000),
    .unlock     (1'b0),
    .button_0   (g_button_0),
    .button_1   (g_button_1),
    .busy       (g_busy),
    .done       (g_done),
    .success    (g_success)
  );

  // Simple Moore lock: opens after the five presses of the default code in order
  logic [4:0] lk_b0 = 5'b10100;
  logic [4:0] lk_b1 = 5'b01011;
  int         lk_idx;
  always @(posedge clk) begin
    if (!rst) begin
      lk_idx <= 0;
    end else if (lk_idx < 5 && (button_0 || button_1)) begin
      if (button_0 == lk_b0[lk_idx] && button_1 == lk_b1[lk_idx]) lk_idx <= lk_idx + 1;
      else lk_idx <= 0;
    end
  end
  assign unlock = use_lock && (lk_idx == 5);

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Pulse start (and any pending load_en), then check the five steps on the default instance
  task automatic send_and_check(input logic [4:0] e0, input logic [4:0] e1, input string tag);
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    load_en = 1'b0;
    check_eq({tag, "_success_clr"}, 32'(success), 32'd0);
    for (int k = 0; k < 5; k++) begin
      check_eq({tag, "_b0"}, 32'(button_0), 32'(e0[k]));
      check_eq({tag, "_b1"}, 32'(button_1), 32'(e1[k]));
      check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
    end
  endtask

  // Advance until done or the limit expires; n is the number of cycles advanced
  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (!done && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [4:0] e0, e1;
    int         n, done_cnt, done_at;

    rst = 1'b0; start = 1'b0; load_en = 1'b0; use_lock = 1'b0; g_start = 1'b0;
    code_b0_in = '0; code_b1_in = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_b0", 32'(button_0), 32'd0);
    check_eq("rst_b1", 32'(button_1), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(done), 32'd0);
    check_eq("rst_success", 32'(success), 32'd0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Default code against the lock model: opens in the first WAIT cycle
    use_lock = 1'b1;
    send_and_check(5'b10100, 5'b01011, "t1");
    wait_done(10, n);
    check_eq("t1_latency", 32'(n), 32'd1);
    check_eq("t1_done", 32'(done), 32'd1);
    check_eq("t1_success", 32'(success), 32'd1);
    check_eq("t1_busy_done", 32'(busy), 32'd1);
    @(negedge clk);
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    check_eq("t1_done_after", 32'(done), 32'd0);
    check_eq("t1_success_held", 32'(success), 32'd1);
    use_lock = 1'b0;
    repeat (2) @(negedge clk);

    // No unlock: eight WAIT cycles, done with failure on the 14th cycle after start
    send_and_check(5'b10100, 5'b01011, "t2");
    for (int i = 0; i < 8; i++) begin
      check_eq("t2_wait_done", 32'(done), 32'd0);
      check_eq("t2_wait_b0", 32'(button_0), 32'd0);
      check_eq("t2_wait_busy", 32'(busy), 32'd1);
      @(negedge clk);
    end
    check_eq("t2_done", 32'(done), 32'd1);
    check_eq("t2_success", 32'(success), 32'd0);
    @(negedge clk);
    check_eq("t2_busy_after", 32'(busy), 32'd0);
    check_eq("t2_done_after", 32'(done), 32'd0);
    repeat (2) @(negedge clk);

    // Load and start together: new code is the one transmitted
    code_b0_in = 5'b00011;
    code_b1_in = 5'b11100;
    load_en    = 1'b1;
    send_and_check(5'b00011, 5'b11100, "t3");
    wait_done(12, n);
    check_eq("t3_latency", 32'(n), 32'd8);
    check_eq("t3_done", 32'(done), 32'd1);
    check_eq("t3_success", 32'(success), 32'd0);
    repeat (3) @(negedge clk);

    // start/load_en re-pulsed while busy, and start in the DONE cycle, are all dropped
    e0 = 5'b00011;
    e1 = 5'b11100;
    done_cnt = 0;
    done_at  = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c <= 5) begin
        check_eq("t4_b0", 32'(button_0), 32'(e0[c-1]));
        check_eq("t4_b1", 32'(button_1), 32'(e1[c-1]));
      end
      if (done) begin
        done_cnt++;
        done_at = c;
      end
      if (c == 15 || c == 16) check_eq("t4_idle_after_done_start", 32'(busy), 32'd0);
      start   = (c == 3) || (c == 8) || (c == 14);
      load_en = (c == 3);
      code_b0_in = 5'b11111;
      code_b1_in = 5'b11111;
      @(negedge clk);
    end
    start   = 1'b0;
    load_en = 1'b0;
    check_eq("t4_done_count", 32'(done_cnt), 32'd1);
    check_eq("t4_done_cycle", 32'(done_at), 32'd14);

    // Reset during step 2 aborts; next start replays the default code
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("t5_step2_b1", 32'(button_1), 32'd1);
    rst = 1'b0;
    @(negedge clk);
    check_eq("t5_rst_b0", 32'(button_0), 32'd0);
    check_eq("t5_rst_b1", 32'(button_1), 32'd0);
    check_eq("t5_rst_busy", 32'(busy), 32'd0);
    check_eq("t5_rst_done", 32'(done), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("t5_idle_done", 32'(done), 32'd0);
    send_and_check(5'b10100, 5'b01011, "t5");
    wait_done(12, n);
    check_eq("t5_done", 32'(done), 32'd1);
    repeat (2) @(negedge clk);

    // Gapped instance: steps every third cycle, two idle cycles between
    e0 = 5'b10100;
    e1 = 5'b01011;
    g_start = 1'b1;
    @(negedge clk);
    g_start = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      logic x0, x1;
      x0 = 1'b0;
      x1 = 1'b0;
      if (c % 3 == 0) begin
        x0 = e0[c/3];
        x1 = e1[c/3];
      end
      check_eq("t6_b0", 32'(g_button_0), 32'(x0));
      check_eq("t6_b1", 32'(g_button_1), 32'(x1));
      check_eq("t6_busy", 32'(g_busy), 32'd1);
      @(negedge clk);
    end
    n = 0;
    while (!g_done && n < 12) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_latency", 32'(n), 32'd8);
    check_eq("t6_done", 32'(g_done), 32'd1);
    check_eq("t6_success", 32'(g_success), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
